// File: rtl/mux_stream_n_if.sv
// Stream bundle for mux_stream_n: N input channels in, one tagged output stream.
// The slave modport is the mux side; the master modport drives producers/consumer.
interface mux_stream_n_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] IN_DATA;
  logic [CHANNELS-1:0]       IN_VALID;
  logic [CHANNELS-1:0]       IN_READY;
  logic [SELW-1:0]           SELECT;
  logic                      MODE;
  logic [WIDTH-1:0]          OUT_DATA;
  logic                      OUT_VALID;
  logic                      OUT_READY;
  logic [SELW-1:0]           OUT_CHANNEL;

  modport slave (
    input  IN_DATA, IN_VALID, SELECT, MODE, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, OUT_CHANNEL
  );

  modport master (
    output IN_DATA, IN_VALID, SELECT, MODE, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, OUT_CHANNEL
  );
endinterface

// File: rtl/mux_stream_n.sv
// N-channel registered stream mux, direct or round-robin selection.
// Define MUX_SKID_EN to add a skid entry that decouples OUT_READY from IN_READY.
module mux_stream_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  mux_stream_n_if.slave bus
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     ptr_q, ptr_d;
  logic [SELW-1:0]     chosen;
  logic                chosen_vld;
  logic [WIDTH-1:0]    in_word;
  logic [CHANNELS-1:0] rdy;
  logic                load_ok;
  logic                xfer;

`ifdef MUX_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SELW-1:0]  skid_ch_q, skid_ch_d;
  logic             skid_valid_q, skid_valid_d;

  assign load_ok = !skid_valid_q;
`else
  assign load_ok = !out_valid_q || bus.OUT_READY;
`endif

  // Round-robin scans downward so the channel nearest PTR wins.
  always_comb begin
    int idx;
    idx        = 0;
    chosen     = '0;
    chosen_vld = 1'b0;
    if (!bus.MODE) begin
      chosen     = bus.SELECT;
      chosen_vld = int'(bus.SELECT) < CHANNELS;
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (bus.IN_VALID[idx]) begin
          chosen     = SELW'(idx);
          chosen_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_word = '0;
    rdy     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chosen == SELW'(i)) begin
        in_word = bus.IN_DATA[i*WIDTH +: WIDTH];
        rdy[i]  = load_ok && chosen_vld;
      end
    end
  end

  assign xfer         = |(rdy & bus.IN_VALID);
  assign bus.IN_READY = rdy;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && bus.MODE) begin
      ptr_d = (chosen == LAST) ? '0 : chosen + 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
`ifdef MUX_SKID_EN
    skid_data_d  = skid_data_q;
    skid_ch_d    = skid_ch_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || bus.OUT_READY) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_ch_d     = skid_ch_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (xfer) begin
        out_data_d  = in_word;
        out_ch_d    = chosen;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (xfer) begin
      skid_data_d  = in_word;
      skid_ch_d    = chosen;
      skid_valid_d = 1'b1;
    end
`else
    if (xfer) begin
      out_data_d  = in_word;
      out_ch_d    = chosen;
      out_valid_d = 1'b1;
    end else if (bus.OUT_READY) begin
      out_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef MUX_SKID_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      skid_data_q  <= '0;
      skid_ch_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_data_q  <= skid_data_d;
      skid_ch_q    <= skid_ch_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`endif

  assign bus.OUT_DATA    = out_data_q;
  assign bus.OUT_CHANNEL = out_ch_q;
  assign bus.OUT_VALID   = out_valid_q;
endmodule
